seq_wave_gen: RTL

- Parametrised multi-step, multi-channel waveform sequencer.
- Steps through STEPS programmable segments. Each segment has its own duration and per-channel output level.
- Runs one-shot or continuous. Has start/stop control, a busy flag, a done pulse, and debug taps for the step counter and step index.
- Drives test stimulus and timing patterns (e.g. LED/strobe sequences) inside the test designs.

---
 rtl/seq_wave_gen.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/seq_wave_gen.sv
// Multi-step, multi-channel waveform sequencer: walks STEPS segments, each with
// its own duration and per-channel level, in one-shot or continuous mode.
module seq_wave_gen #(
    parameter int            STEPS    = 4,
    parameter int            CH       = 1,
    parameter int            CW       = 5,
    parameter int            SW       = 2,
    parameter logic [CH-1:0] IDLE_LVL = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  mode,
    input  logic [STEPS*CW-1:0]   step_dur,
    input  logic [STEPS*CH-1:0]   step_lvl,
    output logic [CH-1:0]         q,
    output logic                  busy,
    output logic                  done,
    output logic [CW-1:0]         sq_cnt,
    output logic [SW-1:0]         sq_step
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [SW-1:0]         step_q, step_d;
    logic [CH-1:0]         q_q, q_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [STEPS*CW-1:0]   dur_sh_q, dur_sh_d;
    logic [STEPS*CH-1:0]   lvl_sh_q, lvl_sh_d;

    int unsigned           step_i;
    logic [CW-1:0]         cur_dur;
    logic [CH-1:0]         next_lvl;
    logic                  last_step;

    // start/stop are single-cycle requests sampled on each rising edge; stop
    // always wins, and start is only honoured while IDLE.
    always_comb begin
        step_i    = 32'(step_q);
        cur_dur   = dur_sh_q[step_i*CW +: CW];
        next_lvl  = lvl_sh_q[(step_i+1)*CH +: CH];
        last_step = (step_q == SW'(STEPS-1));
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        step_d   = step_q;
        q_d      = q_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        dur_sh_d = dur_sh_q;
        lvl_sh_d = lvl_sh_q;
        unique case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    state_d  = RUN;
                    busy_d   = 1'b1;
                    cnt_d    = '0;
                    step_d   = '0;
                    q_d      = step_lvl[CH-1:0];
                    dur_sh_d = step_dur;
                    lvl_sh_d = step_lvl;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    q_d     = IDLE_LVL;
                    cnt_d   = '0;
                    step_d  = '0;
                end else if (cnt_q != cur_dur) begin
                    cnt_d = cnt_q + CW'(1);
                end else if (!last_step) begin
                    cnt_d  = '0;
                    step_d = step_q + SW'(1);
                    q_d    = next_lvl;
                end else if (mode) begin
                    // Continuous wrap: tables refresh from the live inputs here.
                    cnt_d    = '0;
                    step_d   = '0;
                    q_d      = step_lvl[CH-1:0];
                    dur_sh_d = step_dur;
                    lvl_sh_d = step_lvl;
                end else begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    q_d     = IDLE_LVL;
                    cnt_d   = '0;
                    step_d  = '0;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                q_d     = IDLE_LVL;
                cnt_d   = '0;
                step_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            step_q   <= '0;
            q_q      <= IDLE_LVL;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dur_sh_q <= '0;
            lvl_sh_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            step_q   <= step_d;
            q_q      <= q_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dur_sh_q <= dur_sh_d;
            lvl_sh_q <= lvl_sh_d;
        end
    end

    assign q       = q_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign sq_cnt  = cnt_q;
    assign sq_step = step_q;

endmodule
